// File: rtl/store_align_split_pkg.sv
// Shared definitions for the store alignment/split path: op encodings,
// op->size helper and FSM state encodings.
package store_align_split_pkg;

  localparam logic [1:0] STORE_OP_SB = 2'd0;
  localparam logic [1:0] STORE_OP_SH = 2'd1;
  localparam logic [1:0] STORE_OP_SW = 2'd2;
  localparam logic [1:0] STORE_OP_SD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_t;

  // Store size in bytes: 1, 2, 4 or 8.
  function automatic logic [3:0] op_size(input logic [1:0] op);
    return 4'd1 << op;
  endfunction

endpackage

// File: rtl/store_align_split_lane_shift.sv
// Combinational lane placement: (word offset, op, data) -> lane-shifted data,
// byte strobes, spill and illegal flags. Upper half exists only with MISALIGNED_SPLIT_EN.
module store_lane_shift
  import store_align_split_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [OFFW-1:0] off_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] sh_lo_o,
  output logic [NB-1:0]   st_lo_o,
`ifdef MISALIGNED_SPLIT_EN
  output logic [XLEN-1:0] sh_hi_o,
  output logic [NB-1:0]   st_hi_o,
`endif
  output logic            spill_o,
  output logic            illegal_o
);

  logic [NB-1:0]   bmask;
  logic [XLEN-1:0] data_m;
  logic [4:0]      end_off;

  always_comb begin
    case (op_i)
      STORE_OP_SB: bmask = NB'(1);
      STORE_OP_SH: bmask = NB'(3);
      STORE_OP_SW: bmask = NB'(15);
      default:     bmask = '1;
    endcase
  end

  // Bytes above the store size are zeroed so unstrobed lanes always read 0.
  always_comb begin
    data_m = '0;
    for (int i = 0; i < NB; i++) begin
      data_m[8*i +: 8] = bmask[i] ? data_i[8*i +: 8] : 8'h00;
    end
  end

  assign end_off   = 5'(off_i) + 5'(op_size(op_i));
  assign spill_o   = end_off > 5'(NB);
  assign illegal_o = (op_i == STORE_OP_SD) && (XLEN == 32);

`ifdef MISALIGNED_SPLIT_EN
  logic [2*XLEN-1:0] sh;
  logic [2*NB-1:0]   st;

  assign sh      = {{XLEN{1'b0}}, data_m} << {off_i, 3'b000};
  assign st      = {{NB{1'b0}}, bmask} << off_i;
  assign sh_lo_o = sh[XLEN-1:0];
  assign sh_hi_o = sh[2*XLEN-1:XLEN];
  assign st_lo_o = st[NB-1:0];
  assign st_hi_o = st[2*NB-1:NB];
`else
  assign sh_lo_o = data_m << {off_i, 3'b000};
  assign st_lo_o = bmask << off_i;
`endif

endmodule

// File: rtl/store_align_split.sv
// Store path: accepts one store, issues one or two bus beats with stable payload.
// MISALIGNED_SPLIT_EN enables two-beat issue of word-crossing stores; otherwise they fault.
module store_align_split
  import store_align_split_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_op,
  input  logic [XLEN-1:0]     req_data,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN-1:0]     bus_wdata,
  output logic [XLEN/8-1:0]   bus_wstrb,
  output logic                done,
  output logic                fault,
  output logic [1:0]          dbg_state
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // bus_valid, once high, stays high with an unchanged payload until bus_ready.

  state_t            state_q, state_d;
  logic              bus_valid_q, bus_valid_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
  logic [NB-1:0]     bus_wstrb_q, bus_wstrb_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;

  logic [XLEN-1:0]   sh_lo;
  logic [NB-1:0]     st_lo;
  logic              spill, illegal, reject;
  logic [ADDR_W-1:0] word_addr;

`ifdef MISALIGNED_SPLIT_EN
  logic [XLEN-1:0]   sh_hi, hi_wdata_q, hi_wdata_d;
  logic [NB-1:0]     st_hi, hi_wstrb_q, hi_wstrb_d;
  logic              spill_q, spill_d;
`endif

  store_lane_shift #(.XLEN(XLEN)) u_shift (
    .off_i     (req_addr[OFFW-1:0]),
    .op_i      (req_op),
    .data_i    (req_data),
    .sh_lo_o   (sh_lo),
    .st_lo_o   (st_lo),
`ifdef MISALIGNED_SPLIT_EN
    .sh_hi_o   (sh_hi),
    .st_hi_o   (st_hi),
`endif
    .spill_o   (spill),
    .illegal_o (illegal)
  );

  assign word_addr = req_addr & ~ADDR_W'(NB - 1);

`ifdef MISALIGNED_SPLIT_EN
  assign reject = illegal;
`else
  assign reject = illegal | spill;
`endif

  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
    hi_wdata_d  = hi_wdata_q;
    hi_wstrb_d  = hi_wstrb_q;
    spill_d     = spill_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (reject) begin
            fault_d = 1'b1;
          end else begin
            state_d     = ST_BEAT0;
            bus_valid_d = 1'b1;
            bus_addr_d  = word_addr;
            bus_wdata_d = sh_lo;
            bus_wstrb_d = st_lo;
`ifdef MISALIGNED_SPLIT_EN
            hi_wdata_d  = sh_hi;
            hi_wstrb_d  = st_hi;
            spill_d     = spill;
`endif
          end
        end
      end
      ST_BEAT0: begin
        if (bus_ready) begin
`ifdef MISALIGNED_SPLIT_EN
          if (spill_q) begin
            state_d     = ST_BEAT1;
            bus_addr_d  = bus_addr_q + ADDR_W'(NB);
            bus_wdata_d = hi_wdata_q;
            bus_wstrb_d = hi_wstrb_q;
          end else begin
            state_d     = ST_IDLE;
            bus_valid_d = 1'b0;
            done_d      = 1'b1;
          end
`else
          state_d     = ST_IDLE;
          bus_valid_d = 1'b0;
          done_d      = 1'b1;
`endif
        end
      end
      ST_BEAT1: begin
        if (bus_ready) begin
          state_d     = ST_IDLE;
          bus_valid_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

`ifdef MISALIGNED_SPLIT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_wdata_q <= '0;
      hi_wstrb_q <= '0;
      spill_q    <= 1'b0;
    end else begin
      hi_wdata_q <= hi_wdata_d;
      hi_wstrb_q <= hi_wstrb_d;
      spill_q    <= spill_d;
    end
  end
`endif

  assign req_ready = (state_q == ST_IDLE);
  assign bus_valid = bus_valid_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_store_align_split.sv
// Directed + table-driven bench for store_align_split (XLEN=64 main instance,
// XLEN=32 side instance). Honors MISALIGNED_SPLIT_EN when defined.
module tb_store_align_split;
  import store_align_split_pkg::*;

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // XLEN=64 instance
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_op;
  logic [63:0] req_data;
  logic        bus_valid, bus_ready;
  logic [31:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        done, fault;
  logic [1:0]  dbg_state;

  logic fixed_ready, rand_mode, rand_bit;
  assign bus_ready = rand_mode ? rand_bit : fixed_ready;
  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  store_align_split #(.XLEN(64), .ADDR_W(32)) u_dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_data(req_data),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .done(done), .fault(fault), .dbg_state(dbg_state)
  );

  // XLEN=32 instance
  logic        r_req_valid, r_req_ready;
  logic [31:0] r_req_addr;
  logic [1:0]  r_req_op;
  logic [31:0] r_req_data;
  logic        r_bus_valid, r_bus_ready;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [3:0]  r_bus_wstrb;
  logic        r_done, r_fault;
  logic [1:0]  r_dbg_state;

  store_align_split #(.XLEN(32), .ADDR_W(32)) u_dut32 (
    .clk(clk), .resetn(resetn),
    .req_valid(r_req_valid), .req_ready(r_req_ready), .req_addr(r_req_addr),
    .req_op(r_req_op), .req_data(r_req_data),
    .bus_valid(r_bus_valid), .bus_ready(r_bus_ready), .bus_addr(r_bus_addr),
    .bus_wdata(r_bus_wdata), .bus_wstrb(r_bus_wstrb),
    .done(r_done), .fault(r_fault), .dbg_state(r_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_err = 0;
  int n_acc = 0, n_abandon = 0;
  int beat_cnt = 0, done_cnt = 0, fault_cnt = 0;
  logic [103:0] exp_q[$];
  logic [103:0] exp_e;
  logic [7:0]   mem [logic [31:0]];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: every handshake is compared against the expected-beat queue
  // and applied to the byte-mask memory model.
  always @(negedge clk) begin
    if (resetn && bus_valid && bus_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got addr 0x%0h expected no beat", bus_addr);
      end else begin
        exp_e = exp_q.pop_front();
        check("beat_payload", {bus_addr, bus_wstrb, bus_wdata}, exp_e);
      end
      for (int i = 0; i < 8; i++)
        if (bus_wstrb[i]) mem[bus_addr + 32'(i)] = bus_wdata[8*i +: 8];
      beat_cnt++;
    end
    if (done) done_cnt++;
    if (fault) fault_cnt++;
    if (done && fault) check("done_fault_exclusive", 1, 0);
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [63:0] data);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_acc++;
  endtask

  task automatic wait_done(output int lat, output bit f);
    lat = 0;
    f = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (done || fault) begin
        lat = k;
        f = fault;
        break;
      end
      check("req_ready_busy", req_ready, 0);
    end
    if (lat == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL completion_timeout: got no done/fault expected one within 200 cycles");
    end
  endtask

  task automatic mem_check(input logic [1:0] op, input logic [31:0] addr, input logic [63:0] data);
    logic [8:0] act;
    logic [31:0] a;
    for (int i = 0; i < (1 << op); i++) begin
      a = addr + 32'(i);
      act = mem.exists(a) ? {1'b0, mem[a]} : 9'h100;
      check("mem_byte", act, {1'b0, data[8*i +: 8]});
    end
  endtask

  // Independent per-byte model of beat payloads (used for random stores).
  task automatic model_beats(input logic [1:0] op, input logic [31:0] addr, input logic [63:0] data,
                             output bit spill_m);
    logic [31:0] w0, ba;
    logic [7:0]  s0, s1;
    logic [63:0] d0, d1;
    w0 = addr & ~32'h7;
    s0 = '0; s1 = '0; d0 = '0; d1 = '0;
    for (int i = 0; i < (1 << op); i++) begin
      ba = addr + 32'(i);
      if ((ba & ~32'h7) == w0) begin
        s0[ba[2:0]] = 1'b1;
        d0[8*ba[2:0] +: 8] = data[8*i +: 8];
      end else begin
        s1[ba[2:0]] = 1'b1;
        d1[8*ba[2:0] +: 8] = data[8*i +: 8];
      end
    end
    spill_m = (s1 != 0);
    if (SPLIT || !spill_m) begin
      exp_q.push_back({w0, s0, d0});
      if (spill_m) exp_q.push_back({w0 + 32'd8, s1, d1});
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [63:0] data;
    bit          flt;
    int          lat;
    logic [31:0] a0;
    logic [7:0]  s0;
    logic [63:0] d0;
    logic [31:0] a1;
    logic [7:0]  s1;
    logic [63:0] d1;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, nb_exp, bc, dc;
    bit f, spill_m;
    logic [1:0]  rop;
    logic [31:0] raddr;
    logic [63:0] rdata;

    vecs[0] = '{STORE_OP_SB, 32'h1003, 64'hAB, 1'b0, 2, 32'h1000, 8'h08, 64'h0000_0000_AB00_0000, 0, 0, 0};
    vecs[2] = '{STORE_OP_SH, 32'h4002, 64'hBEEF, 1'b0, 2, 32'h4000, 8'h0C, 64'h0000_0000_BEEF_0000, 0, 0, 0};
    vecs[3] = '{STORE_OP_SD, 32'h3000, 64'h0123_4567_89AB_CDEF, 1'b0, 2, 32'h3000, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0, 0};
    vecs[4] = '{STORE_OP_SW, 32'h5004, 64'hDEAD_BEEF, 1'b0, 2, 32'h5000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 0, 0, 0};
    vecs[5] = '{STORE_OP_SB, 32'h6007, 64'hFFFF_FFFF_FFFF_FF5A, 1'b0, 2, 32'h6000, 8'h80, 64'h5A00_0000_0000_0000, 0, 0, 0};
    vecs[8] = '{STORE_OP_SH, 32'hFFFF_FFFE, 64'h1234, 1'b0, 2, 32'hFFFF_FFF8, 8'hC0, 64'h1234_0000_0000_0000, 0, 0, 0};
`ifdef MISALIGNED_SPLIT_EN
    vecs[1] = '{STORE_OP_SW, 32'h2006, 64'h1122_3344, 1'b0, 3, 32'h2000, 8'hC0, 64'h3344_0000_0000_0000, 32'h2008, 8'h03, 64'h1122};
    vecs[6] = '{STORE_OP_SH, 32'h7007, 64'hCAFE, 1'b0, 3, 32'h7000, 8'h80, 64'hFE00_0000_0000_0000, 32'h7008, 8'h01, 64'hCA};
    vecs[7] = '{STORE_OP_SD, 32'h8001, 64'h1122_3344_5566_7788, 1'b0, 3, 32'h8000, 8'hFE, 64'h2233_4455_6677_8800, 32'h8008, 8'h01, 64'h11};
`else
    vecs[1] = '{STORE_OP_SW, 32'h2006, 64'h1122_3344, 1'b1, 1, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{STORE_OP_SH, 32'h7007, 64'hCAFE, 1'b1, 1, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{STORE_OP_SD, 32'h8001, 64'h1122_3344_5566_7788, 1'b1, 1, 0, 0, 0, 0, 0, 0};
`endif

    resetn = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_op = '0; req_data = '0;
    r_req_valid = 1'b0; r_req_addr = '0; r_req_op = '0; r_req_data = '0;
    r_bus_ready = 1'b1;
    fixed_ready = 1'b1; rand_mode = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_bus_wstrb", bus_wstrb, 0);
    check("rst_state", dbg_state, ST_IDLE);
    resetn = 1'b1;

    // Table-driven stores with bus_ready held high
    for (int v = 0; v < 9; v++) begin
      if (!vecs[v].flt) begin
        exp_q.push_back({vecs[v].a0, vecs[v].s0, vecs[v].d0});
        if (vecs[v].s1 != 0) exp_q.push_back({vecs[v].a1, vecs[v].s1, vecs[v].d1});
      end
      nb_exp = vecs[v].flt ? 0 : ((vecs[v].s1 != 0) ? 2 : 1);
      bc = beat_cnt;
      issue(vecs[v].op, vecs[v].addr, vecs[v].data);
      wait_done(lat, f);
      check($sformatf("v%0d_fault", v), f, vecs[v].flt);
      check($sformatf("v%0d_latency", v), lat, vecs[v].lat);
      check($sformatf("v%0d_beats", v), beat_cnt - bc, nb_exp);
      check($sformatf("v%0d_valid_low", v), bus_valid, 0);
      if (!vecs[v].flt) mem_check(vecs[v].op, vecs[v].addr, vecs[v].data);
    end

    // Back-pressure: SD held for 5 stalled cycles
    fixed_ready = 1'b0;
    exp_q.push_back({32'h3000, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0});
    bc = beat_cnt;
    issue(STORE_OP_SD, 32'h3000, 64'hA5A5_5A5A_0F0F_F0F0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", bus_valid, 1);
      check("bp_payload", {bus_addr, bus_wstrb, bus_wdata}, {32'h3000, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0});
      check("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    fixed_ready = 1'b1;
    wait_done(lat, f);
    check("bp_fault", f, 0);
    check("bp_one_handshake", beat_cnt - bc, 1);
    mem_check(STORE_OP_SD, 32'h3000, 64'hA5A5_5A5A_0F0F_F0F0);

    // XLEN=32: SD faults
    @(posedge clk); #1;
    r_req_valid = 1'b1; r_req_op = STORE_OP_SD; r_req_addr = 32'h100; r_req_data = 32'h1234_5678;
    @(posedge clk); #1;
    r_req_valid = 1'b0;
    @(negedge clk);
    check("x32_sd_fault", r_fault, 1);
    check("x32_sd_no_valid", r_bus_valid, 0);
    check("x32_sd_ready", r_req_ready, 1);
    @(negedge clk);
    check("x32_sd_fault_pulse", r_fault, 0);

    // XLEN=32: SH at 0xFFFFFFFF wraps to address 0 for beat1
    @(posedge clk); #1;
    r_req_valid = 1'b1; r_req_op = STORE_OP_SH; r_req_addr = 32'hFFFF_FFFF; r_req_data = 32'hBEEF;
    @(posedge clk); #1;
    r_req_valid = 1'b0;
    @(negedge clk);
`ifdef MISALIGNED_SPLIT_EN
    check("x32_wrap_b0", {r_bus_valid, r_bus_addr, r_bus_wstrb, r_bus_wdata}, {1'b1, 32'hFFFF_FFFC, 4'h8, 32'hEF00_0000});
    @(negedge clk);
    check("x32_wrap_b1", {r_bus_valid, r_bus_addr, r_bus_wstrb, r_bus_wdata}, {1'b1, 32'h0, 4'h1, 32'h0000_00BE});
    @(negedge clk);
    check("x32_wrap_done", {r_done, r_fault, r_bus_valid}, 3'b100);
`else
    check("x32_spill_fault", {r_done, r_fault, r_bus_valid}, 3'b010);
`endif

    // Reset while a beat is pending: bus_valid drops asynchronously, no done
    dc = done_cnt;
`ifdef MISALIGNED_SPLIT_EN
    fixed_ready = 1'b1;
    exp_q.push_back({32'h7000, 8'h80, 64'hFE00_0000_0000_0000});
    issue(STORE_OP_SH, 32'h7007, 64'hCAFE);
    @(posedge clk); #1;
    fixed_ready = 1'b0;
    @(negedge clk);
    check("rm_pending_valid", bus_valid, 1);
    check("rm_pending_addr", bus_addr, 32'h7008);
`else
    fixed_ready = 1'b0;
    issue(STORE_OP_SB, 32'h1003, 64'hAB);
    @(negedge clk);
    check("rm_pending_valid", bus_valid, 1);
    check("rm_pending_addr", bus_addr, 32'h1000);
`endif
    #1 resetn = 1'b0;
    #1;
    check("rm_valid_async", bus_valid, 0);
    check("rm_ready", req_ready, 1);
    check("rm_state", dbg_state, ST_IDLE);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    n_abandon++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rm_post_idle", {done, fault, bus_valid, req_ready}, 4'b0001);
    end
    check("rm_no_done", done_cnt - dc, 0);
    fixed_ready = 1'b1;

    // Random ops/addresses with random bus_ready
    rand_mode = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rop   = 2'($urandom_range(0, 3));
      raddr = 32'h9000 + 32'($urandom_range(0, 63));
      rdata = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) if (i >= (1 << rop)) rdata[8*i +: 8] = 8'h00;
      model_beats(rop, raddr, rdata, spill_m);
      bc = beat_cnt;
      issue(rop, raddr, rdata);
      wait_done(lat, f);
      check("rnd_fault", f, spill_m && !SPLIT);
      if (!f) mem_check(rop, raddr, rdata);
      if (f) check("rnd_fault_no_beat", beat_cnt - bc, 0);
    end
    rand_mode = 1'b0;

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("one_pulse_per_accept", done_cnt + fault_cnt, n_acc - n_abandon);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
